// File: rtl/lif_cfg_pkg.sv
// Shared definitions for the lif_neuron configuration loader: FSM states,
// error codes, B1 field positions and the default frame header.
package lif_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_W   = 3'd1,
    GET_MIN = 3'd2,
    GET_MAX = 3'd3,
    GET_CK  = 3'd4,
    APPLY   = 3'd5
  } cfg_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // B1 packs {weight_a, weight_b, leak}
  localparam int WA_MSB = 7;
  localparam int WA_LSB = 5;
  localparam int WB_MSB = 4;
  localparam int WB_LSB = 2;
  localparam int LK_MSB = 1;
  localparam int LK_LSB = 0;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/lif_config_loader.sv
// Byte-serial frame loader that validates a parameter packet and applies it
// atomically to one lif_neuron, sequencing re-init and enable around the update.
module lif_config_loader
  import lif_cfg_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEF,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] DEF_THR_MIN    = 8'd16,
  parameter logic [7:0] DEF_THR_MAX    = 8'd64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       run_en,
  output logic [2:0] weight_a_out,
  output logic [2:0] weight_b_out,
  output logic [1:0] leak_cfg_out,
  output logic [7:0] thr_min_out,
  output logic [7:0] thr_max_out,
  output logic       params_ready,
  output logic       neuron_reset,
  output logic       neuron_enable,
  output logic       err_sticky,
  output logic [1:0] err_code,
  output logic [3:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  cfg_state_t    state, state_next;
  logic [7:0]    sh_w, sh_min, sh_max;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          cfg_valid;
  logic          take, in_frame;
  logic          ld_w, ld_min, ld_max, clr_shadow, apply, err_hit;
  logic [1:0]    err_val;

  assign byte_ready    = (state != APPLY);
  assign take          = byte_valid && byte_ready;
  assign in_frame      = (state == GET_W) || (state == GET_MIN) ||
                         (state == GET_MAX) || (state == GET_CK);
  assign neuron_reset  = (state == APPLY);
  // The neuron sees not-ready during the re-init cycle even when a config exists
  assign params_ready  = cfg_valid && (state != APPLY);
  assign neuron_enable = run_en && params_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    ld_w       = 1'b0;
    ld_min     = 1'b0;
    ld_max     = 1'b0;
    clr_shadow = 1'b0;
    apply      = 1'b0;
    err_hit    = 1'b0;
    err_val    = ERR_NONE;
    unique case (state)
      IDLE:    if (take && byte_in == HEADER) state_next = GET_W;
      GET_W:   if (take) begin ld_w = 1'b1;   state_next = GET_MIN; end
      GET_MIN: if (take) begin ld_min = 1'b1; state_next = GET_MAX; end
      GET_MAX: if (take) begin ld_max = 1'b1; state_next = GET_CK;  end
      GET_CK: begin
        if (take) begin
          if (byte_in != (sh_w ^ sh_min ^ sh_max)) begin
            err_hit    = 1'b1;
            err_val    = ERR_CHECKSUM;
            state_next = IDLE;
          end else if (sh_min > sh_max) begin
            err_hit    = 1'b1;
            err_val    = ERR_RANGE;
            state_next = IDLE;
          end else begin
            state_next = APPLY;
          end
        end
      end
      APPLY: begin
        apply      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Inter-byte watchdog: the last idle cycle of the budget aborts the frame
    if (!in_frame || take) begin
      tcnt_next = '0;
    end else if (tcnt == TCNT_LAST) begin
      tcnt_next  = '0;
      err_hit    = 1'b1;
      err_val    = ERR_TIMEOUT;
      clr_shadow = 1'b1;
      state_next = IDLE;
    end else begin
      tcnt_next = tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt         <= '0;
      sh_w         <= '0;
      sh_min       <= '0;
      sh_max       <= '0;
      weight_a_out <= '0;
      weight_b_out <= '0;
      leak_cfg_out <= '0;
      thr_min_out  <= DEF_THR_MIN;
      thr_max_out  <= DEF_THR_MAX;
      cfg_valid    <= 1'b0;
      err_sticky   <= 1'b0;
      err_code     <= ERR_NONE;
      err_count    <= '0;
    end else begin
      tcnt <= tcnt_next;
      if (ld_w)   sh_w   <= byte_in;
      if (ld_min) sh_min <= byte_in;
      if (ld_max) sh_max <= byte_in;
      if (clr_shadow) begin
        sh_w   <= '0;
        sh_min <= '0;
        sh_max <= '0;
      end
      if (apply) begin
        weight_a_out <= sh_w[WA_MSB:WA_LSB];
        weight_b_out <= sh_w[WB_MSB:WB_LSB];
        leak_cfg_out <= sh_w[LK_MSB:LK_LSB];
        thr_min_out  <= sh_min;
        thr_max_out  <= sh_max;
        cfg_valid    <= 1'b1;
        err_sticky   <= 1'b0;
        err_code     <= ERR_NONE;
      end
      if (err_hit) begin
        err_sticky <= 1'b1;
        err_code   <= err_val;
        if (err_count != 4'd15) err_count <= err_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_lif_config_loader.sv
// Directed self-checking bench for lif_config_loader: framing, latency,
// checksum/range/timeout errors, saturation and asynchronous reset.
module tb_lif_config_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       run_en;
  logic [2:0] weight_a_out, weight_b_out;
  logic [1:0] leak_cfg_out;
  logic [7:0] thr_min_out, thr_max_out;
  logic       params_ready, neuron_reset, neuron_enable, err_sticky;
  logic [1:0] err_code;
  logic [3:0] err_count;

  int num_compared   = 0;
  int num_mismatched = 0;
  int nr_pulses      = 0;
  int nr_before;

  lif_config_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .run_en       (run_en),
    .weight_a_out (weight_a_out),
    .weight_b_out (weight_b_out),
    .leak_cfg_out (leak_cfg_out),
    .thr_min_out  (thr_min_out),
    .thr_max_out  (thr_max_out),
    .params_ready (params_ready),
    .neuron_reset (neuron_reset),
    .neuron_enable(neuron_enable),
    .err_sticky   (err_sticky),
    .err_code     (err_code),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (neuron_reset) nr_pulses++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    num_compared++;
    if (actual != expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one byte from a negedge and returns 1ns after the accepting posedge
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!byte_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) checkOutput("ready_wait", 0, 1);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b1, b2, b3, b4);
    applyStimulus(8'hA5);
    applyStimulus(b1);
    applyStimulus(b2);
    applyStimulus(b3);
    applyStimulus(b4);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    run_en     = 1'b0;
    #12;
    $display("[TB] reset values");
    checkOutput("rst_thr_min", thr_min_out, 16);
    checkOutput("rst_thr_max", thr_max_out, 64);
    checkOutput("rst_weight_a", weight_a_out, 0);
    checkOutput("rst_params_ready", params_ready, 0);
    checkOutput("rst_byte_ready", byte_ready, 1);
    checkOutput("rst_err_count", err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] stray bytes then good frame");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    wait_cycles(1);
    checkOutput("stray_err_sticky", err_sticky, 0);
    send_frame(8'h6E, 8'h14, 8'h50, 8'h2A);
    checkOutput("n1_neuron_reset", neuron_reset, 1);
    checkOutput("n1_params_ready", params_ready, 0);
    checkOutput("n1_byte_ready", byte_ready, 0);
    checkOutput("n1_thr_min_old", thr_min_out, 16);
    wait_cycles(1);
    checkOutput("n2_neuron_reset", neuron_reset, 0);
    checkOutput("n2_params_ready", params_ready, 1);
    checkOutput("n2_weight_a", weight_a_out, 3);
    checkOutput("n2_weight_b", weight_b_out, 3);
    checkOutput("n2_leak", leak_cfg_out, 2);
    checkOutput("n2_thr_min", thr_min_out, 8'h14);
    checkOutput("n2_thr_max", thr_max_out, 8'h50);
    checkOutput("good_pulses", nr_pulses, 1);
    checkOutput("enable_off", neuron_enable, 0);
    run_en = 1'b1;
    #1 checkOutput("enable_on", neuron_enable, 1);
    run_en = 1'b0;

    $display("[TB] bad checksum");
    nr_before = nr_pulses;
    send_frame(8'h6E, 8'h14, 8'h50, 8'h00);
    wait_cycles(3);
    checkOutput("ck_err_code", err_code, 1);
    checkOutput("ck_err_sticky", err_sticky, 1);
    checkOutput("ck_err_count", err_count, 1);
    checkOutput("ck_thr_min", thr_min_out, 8'h14);
    checkOutput("ck_params_ready", params_ready, 1);
    checkOutput("ck_no_pulse", nr_pulses, nr_before);

    $display("[TB] range error");
    send_frame(8'h00, 8'h60, 8'h20, 8'h40);
    wait_cycles(3);
    checkOutput("rg_err_code", err_code, 2);
    checkOutput("rg_err_count", err_count, 2);
    checkOutput("rg_thr_max", thr_max_out, 8'h50);
    checkOutput("rg_no_pulse", nr_pulses, nr_before);

    $display("[TB] timeout");
    applyStimulus(8'hA5);
    applyStimulus(8'h6E);
    wait_cycles(10);
    checkOutput("to_early_code", err_code, 2);
    wait_cycles(10);
    checkOutput("to_err_code", err_code, 3);
    checkOutput("to_err_count", err_count, 3);
    send_frame(8'h8D, 8'h20, 8'h20, 8'h8D);
    wait_cycles(2);
    checkOutput("eq_weight_a", weight_a_out, 4);
    checkOutput("eq_weight_b", weight_b_out, 3);
    checkOutput("eq_leak", leak_cfg_out, 1);
    checkOutput("eq_thr_min", thr_min_out, 8'h20);
    checkOutput("eq_thr_max", thr_max_out, 8'h20);
    checkOutput("eq_err_sticky", err_sticky, 0);
    checkOutput("eq_err_code", err_code, 0);
    checkOutput("eq_err_count", err_count, 3);

    $display("[TB] error count saturation");
    for (int i = 0; i < 17; i++) send_frame(8'h6E, 8'h14, 8'h50, 8'h00);
    wait_cycles(2);
    checkOutput("sat_err_count", err_count, 15);
    checkOutput("sat_err_code", err_code, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    applyStimulus(8'h25);
    applyStimulus(8'h00);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mr_params_ready", params_ready, 0);
    checkOutput("mr_thr_min", thr_min_out, 16);
    checkOutput("mr_thr_max", thr_max_out, 64);
    checkOutput("mr_err_count", err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(8'h25, 8'h00, 8'hFF, 8'hDA);
    wait_cycles(2);
    checkOutput("post_weight_a", weight_a_out, 1);
    checkOutput("post_weight_b", weight_b_out, 1);
    checkOutput("post_leak", leak_cfg_out, 1);
    checkOutput("post_thr_max", thr_max_out, 8'hFF);
    checkOutput("post_params_ready", params_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
